// File: rtl/gf2mz_reduce.sv
// Reduces a streamed 2N-1 coefficient GF(2^M)[z] product modulo z^N + z^K3 + z^K2 + z^K1 + 1.
// Latency: start->in_ready 2 cycles, last input->out_valid 1 cycle, last output->done 1 cycle.
// Backpressure: in_valid gaps and out_ready stalls are tolerated; ready/valid are decoded from state only.
module gf2mz_reduce #(
    parameter int N  = 83,
    parameter int M  = 67,
    parameter int K1 = 2,
    parameter int K2 = 4,
    parameter int K3 = 7
) (
    input  logic         clk,
    input  logic         rst_b,      // active-high asynchronous reset despite the name
    input  logic         start,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] out_data,
    output logic         out_last,
    output logic         busy,
    output logic         done
);

    localparam int D  = 2*N - 1;
    localparam int IW = $clog2(D);
    localparam int JW = $clog2(N);

    localparam logic [IW-1:0] N_I   = IW'(N);
    localparam logic [IW-1:0] K1_I  = IW'(K1);
    localparam logic [IW-1:0] K2_I  = IW'(K2);
    localparam logic [IW-1:0] K3_I  = IW'(K3);
    localparam logic [IW-1:0] TOP_I = IW'(D - 1);
    localparam logic [JW-1:0] LAST_J = JW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_DRAIN,
        S_FIN
    } state_t;

    state_t        state_q;
    logic [IW-1:0] i_q;
    logic [JW-1:0] j_q;
    logic [M-1:0]  acc_q [D];
    logic [M-1:0]  acc_d [D];

    logic          in_hs;
    logic          fold;
    logic [IW-1:0] base;
    logic [M-1:0]  v;

    assign in_hs = in_valid && (state_q == S_LOAD);
    assign fold  = (i_q >= N_I);
    assign base  = i_q - N_I;           // only meaningful when fold is set
    assign v     = in_data ^ acc_q[i_q];

    // Accumulator next state: clear, fold the top coefficient into its four taps, or settle a low one.
    always_comb begin
        for (int k = 0; k < D; k++) begin
            acc_d[k] = acc_q[k];
            if (state_q == S_CLEAR) begin
                acc_d[k] = '0;
            end else if (in_hs) begin
                if (fold) begin
                    // Taps are distinct, so at most one of these matches any slot.
                    if (IW'(k) == base || IW'(k) == base + K1_I ||
                        IW'(k) == base + K2_I || IW'(k) == base + K3_I) begin
                        acc_d[k] = acc_q[k] ^ v;
                    end
                end else if (IW'(k) == i_q) begin
                    acc_d[k] = v;
                end
            end
        end
    end

    // Accumulator registers; contents survive FIN until the next CLEAR.
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            for (int k = 0; k < D; k++) acc_q[k] <= '0;
        end else begin
            for (int k = 0; k < D; k++) acc_q[k] <= acc_d[k];
        end
    end

    // Control FSM with the input-degree and output-index down-counters.
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            j_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) state_q <= S_CLEAR;
                end
                S_CLEAR: begin
                    i_q     <= TOP_I;
                    j_q     <= LAST_J;
                    state_q <= S_LOAD;
                end
                S_LOAD: begin
                    if (in_valid) begin
                        if (i_q == '0) state_q <= S_DRAIN;
                        else           i_q     <= i_q - 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        if (j_q == '0) state_q <= S_FIN;
                        else           j_q     <= j_q - 1'b1;
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs depend on state and counters only, never on in_valid or out_ready.
    always_comb begin
        in_ready  = (state_q == S_LOAD);
        out_valid = (state_q == S_DRAIN);
        out_data  = out_valid ? acc_q[IW'(j_q)] : '0;
        out_last  = out_valid && (j_q == '0);
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_FIN);
    end

endmodule
